// File: rtl/alu_md.sv
// Execute-stage ALU: single-cycle ops plus an iterative radix-2 multiply /
// restoring divide behind a start/busy/ready handshake.
module alu_md #(
  parameter int WIDTH = 32,
  parameter int SHW   = 5
) (
  input  logic             clk,
  input  logic             clrn,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [4:0]       aluc,
  output logic [WIDTH-1:0] r,
  output logic [WIDTH-1:0] hi,
  output logic             z,
  output logic             busy,
  output logic             ready,
  output logic             dz
);

  localparam int CW = SHW + 1;

  typedef enum logic [1:0] {IDLE, MUL, DIV, FIN} state_t;

  // Per-operation context captured at the start edge.
  typedef struct packed {
    logic mul;     // multiply (else divide)
    logic dz;      // divide by zero, no iteration
    logic neg_lo;  // negate product / quotient at FIN
    logic neg_hi;  // negate remainder at FIN
  } op_t;

  state_t             state;
  op_t                op;
  logic [CW-1:0]      cnt;
  logic [WIDTH-1:0]   acc_hi;
  logic [WIDTH-1:0]   acc_lo;
  logic [WIDTH-1:0]   opd;

  // ---------------- single-cycle datapath ----------------
  logic [WIDTH-1:0] sc_res;
  logic [SHW-1:0]   sa;

  assign sa = a[SHW-1:0];

  always_comb begin
    sc_res = '0;
    case (aluc[2:0])
      3'b000: sc_res = a + b;
      3'b100: sc_res = a - b;
      3'b001: sc_res = a & b;
      3'b101: sc_res = a | b;
      3'b010: sc_res = a ^ b;
      3'b110: sc_res = {b[WIDTH/2-1:0], {(WIDTH/2){1'b0}}};
      3'b011: sc_res = b << sa;
      3'b111: sc_res = aluc[3] ? $unsigned($signed(b) >>> sa) : (b >> sa);
      default: sc_res = '0;
    endcase
  end

  // ---------------- operand magnitudes ----------------
  logic             sgn, a_neg, b_neg, is_div;
  logic [WIDTH-1:0] a_mag, b_mag;

  assign sgn    = aluc[0];
  assign is_div = aluc[1];
  assign a_neg  = sgn & a[WIDTH-1];
  assign b_neg  = sgn & b[WIDTH-1];
  assign a_mag  = a_neg ? -a : a;
  assign b_mag  = b_neg ? -b : b;

  // ---------------- iteration steps ----------------
  logic [WIDTH:0] mul_sum;
  logic [WIDTH:0] div_tr;
  logic [WIDTH:0] div_diff;
  logic           div_ge;

  assign mul_sum  = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opd} : {(WIDTH+1){1'b0}});
  // Shift the next dividend bit into the partial remainder, then trial-subtract.
  assign div_tr   = {acc_hi, acc_lo[WIDTH-1]};
  assign div_diff = div_tr - {1'b0, opd};
  assign div_ge   = (div_tr >= {1'b0, opd});

  // ---------------- final sign correction ----------------
  logic [2*WIDTH-1:0] prod, prod_c;
  logic [WIDTH-1:0]   q_c, rem_c, fin_lo, fin_hi;

  assign prod   = {acc_hi, acc_lo};
  assign prod_c = op.neg_lo ? -prod : prod;
  assign q_c    = op.neg_lo ? -acc_lo : acc_lo;
  assign rem_c  = op.neg_hi ? -acc_hi : acc_hi;

  always_comb begin
    fin_lo = q_c;
    fin_hi = rem_c;
    if (op.dz) begin
      fin_lo = acc_lo;
      fin_hi = acc_hi;
    end else if (op.mul) begin
      fin_lo = prod_c[WIDTH-1:0];
      fin_hi = prod_c[2*WIDTH-1:WIDTH];
    end
  end

  // ---------------- control FSM and registered outputs ----------------
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state  <= IDLE;
      op     <= '0;
      cnt    <= '0;
      acc_hi <= '0;
      acc_lo <= '0;
      opd    <= '0;
      r      <= '0;
      hi     <= '0;
      z      <= 1'b1;
      dz     <= 1'b0;
      busy   <= 1'b0;
      ready  <= 1'b0;
    end else begin
      ready <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (!aluc[4]) begin
              r     <= sc_res;
              z     <= ~|sc_res;
              hi    <= '0;
              dz    <= 1'b0;
              ready <= 1'b1;
            end else begin
              busy      <= 1'b1;
              cnt       <= CW'(WIDTH);
              op.mul    <= ~is_div;
              op.neg_lo <= a_neg ^ b_neg;
              op.neg_hi <= a_neg;
              if (is_div && (b == '0)) begin
                // Divide by zero skips iteration: quotient all ones, remainder = a.
                op.dz  <= 1'b1;
                acc_hi <= a;
                acc_lo <= '1;
                state  <= FIN;
              end else begin
                op.dz  <= 1'b0;
                acc_hi <= '0;
                acc_lo <= is_div ? a_mag : b_mag;
                opd    <= is_div ? b_mag : a_mag;
                state  <= is_div ? DIV : MUL;
              end
            end
          end
        end
        MUL: begin
          acc_hi <= mul_sum[WIDTH:1];
          acc_lo <= {mul_sum[0], acc_lo[WIDTH-1:1]};
          cnt    <= cnt - CW'(1);
          if (cnt == CW'(1)) state <= FIN;
        end
        DIV: begin
          acc_hi <= div_ge ? div_diff[WIDTH-1:0] : div_tr[WIDTH-1:0];
          acc_lo <= {acc_lo[WIDTH-2:0], div_ge};
          cnt    <= cnt - CW'(1);
          if (cnt == CW'(1)) state <= FIN;
        end
        FIN: begin
          r     <= fin_lo;
          hi    <= fin_hi;
          z     <= ~|fin_lo;
          dz    <= op.dz;
          busy  <= 1'b0;
          ready <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_md.sv
// Directed self-checking bench for alu_md at WIDTH=32 and WIDTH=16.
module tb_alu_md;

  logic        clk = 1'b0;
  logic        clrn;
  logic        start;
  logic [31:0] a, b;
  logic [4:0]  aluc;
  logic [31:0] r, hi;
  logic        z, busy, ready, dz;

  logic        start16;
  logic [15:0] a16, b16;
  logic [4:0]  aluc16;
  logic [15:0] r16, hi16;
  logic        z16, busy16, ready16, dz16;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_md #(.WIDTH(32), .SHW(5)) dut (
    .clk(clk), .clrn(clrn), .start(start), .a(a), .b(b), .aluc(aluc),
    .r(r), .hi(hi), .z(z), .busy(busy), .ready(ready), .dz(dz)
  );

  alu_md #(.WIDTH(16), .SHW(4)) dut16 (
    .clk(clk), .clrn(clrn), .start(start16), .a(a16), .b(b16), .aluc(aluc16),
    .r(r16), .hi(hi16), .z(z16), .busy(busy16), .ready(ready16), .dz(dz16)
  );

  localparam logic [4:0] ADD = 5'b00000, SUB = 5'b00100, SLL = 5'b00011, SRL = 5'b00111;
  localparam logic [4:0] SRA = 5'b01111, LUI = 5'b00110, XOR = 5'b00010, AND = 5'b00001;
  localparam logic [4:0] MULTU = 5'b10000, MULT = 5'b10001, DIVU = 5'b10010, DIV = 5'b10011;

  // Issue one op at the current negedge, scramble inputs afterwards, and
  // return edges-until-ready and cycles-with-busy (bounded).
  task automatic run_op(input logic [4:0] op, input logic [31:0] av, input logic [31:0] bv,
                        output int lat, output int bcnt);
    a = av; b = bv; aluc = op; start = 1'b1;
    @(negedge clk);
    start = 1'b0; a = ~av; b = ~bv; aluc = ~op;
    lat = 0; bcnt = 0;
    while (!ready && lat < 100) begin
      if (busy) bcnt++;
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic run_op16(input logic [4:0] op, input logic [15:0] av, input logic [15:0] bv,
                          output int lat);
    a16 = av; b16 = bv; aluc16 = op; start16 = 1'b1;
    @(negedge clk);
    start16 = 1'b0; a16 = ~av; b16 = ~bv;
    lat = 0;
    while (!ready16 && lat < 100) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic test_reset();
    clrn = 1'b0; start = 1'b0; a = '0; b = '0; aluc = '0;
    start16 = 1'b0; a16 = '0; b16 = '0; aluc16 = '0;
    repeat (2) @(negedge clk);
    checks++; if (r !== 32'h0) begin errors++; $display("FAIL reset_r got %h exp 0", r); end
    checks++; if (hi !== 32'h0) begin errors++; $display("FAIL reset_hi got %h exp 0", hi); end
    checks++; if ({z, dz, busy, ready} !== 4'b1000) begin errors++; $display("FAIL reset_flags z/dz/busy/ready got %b exp 1000", {z, dz, busy, ready}); end
    checks++; if ({r16, z16, ready16} !== {16'h0, 1'b1, 1'b0}) begin errors++; $display("FAIL reset_w16 r/z/ready got %h/%b/%b exp 0/1/0", r16, z16, ready16); end
    clrn = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_alu();
    int lat, bc;
    run_op(ADD, 32'h7FFFFFFF, 32'h1, lat, bc);
    checks++; if (r !== 32'h80000000) begin errors++; $display("FAIL add_r got %h exp 80000000", r); end
    checks++; if ({z, hi} !== {1'b0, 32'h0}) begin errors++; $display("FAIL add_z_hi got %b/%h exp 0/0", z, hi); end
    checks++; if (lat !== 0 || bc !== 0) begin errors++; $display("FAIL add_timing lat %0d busy %0d exp 0 0", lat, bc); end
    run_op(SUB, 32'd5, 32'd5, lat, bc);
    checks++; if ({r, z} !== {32'h0, 1'b1}) begin errors++; $display("FAIL sub_r_z got %h/%b exp 0/1", r, z); end
    run_op(SRA, 32'd4, 32'h80000000, lat, bc);
    checks++; if (r !== 32'hF8000000) begin errors++; $display("FAIL sra got %h exp f8000000", r); end
    run_op(SRL, 32'd4, 32'h80000000, lat, bc);
    checks++; if (r !== 32'h08000000) begin errors++; $display("FAIL srl got %h exp 08000000", r); end
    run_op(LUI, 32'hDEAD, 32'h1234, lat, bc);
    checks++; if (r !== 32'h12340000) begin errors++; $display("FAIL lui got %h exp 12340000", r); end
    run_op(SLL, 32'd31, 32'h3, lat, bc);
    checks++; if (r !== 32'h80000000) begin errors++; $display("FAIL sll got %h exp 80000000", r); end
  endtask

  task automatic test_mul();
    int lat, bc;
    run_op(MULT, 32'hFFFFFFFD, 32'd5, lat, bc);
    checks++; if ({hi, r} !== 64'hFFFFFFFF_FFFFFFF1) begin errors++; $display("FAIL mult_neg got %h_%h exp ffffffff_fffffff1", hi, r); end
    checks++; if (lat !== 33) begin errors++; $display("FAIL mult_latency got %0d exp 33", lat); end
    checks++; if (bc !== 33) begin errors++; $display("FAIL mult_busy_cycles got %0d exp 33", bc); end
    checks++; if ({z, dz} !== 2'b00) begin errors++; $display("FAIL mult_flags z/dz got %b exp 00", {z, dz}); end
    run_op(MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, lat, bc);
    checks++; if ({hi, r} !== 64'hFFFFFFFE_00000001) begin errors++; $display("FAIL multu_max got %h_%h exp fffffffe_00000001", hi, r); end
  endtask

  task automatic test_div();
    int lat, bc;
    run_op(DIV, 32'hFFFFFFF9, 32'd2, lat, bc);
    checks++; if ({r, hi} !== {32'hFFFFFFFD, 32'hFFFFFFFF}) begin errors++; $display("FAIL div_neg got q %h r %h exp fffffffd ffffffff", r, hi); end
    checks++; if (lat !== 33) begin errors++; $display("FAIL div_latency got %0d exp 33", lat); end
    run_op(DIVU, 32'd100, 32'd7, lat, bc);
    checks++; if ({r, hi} !== {32'd14, 32'd2}) begin errors++; $display("FAIL divu got q %0d r %0d exp 14 2", r, hi); end
    run_op(DIV, 32'h80000000, 32'hFFFFFFFF, lat, bc);
    checks++; if ({r, hi, dz} !== {32'h80000000, 32'h0, 1'b0}) begin errors++; $display("FAIL div_min_m1 got q %h r %h dz %b exp 80000000 0 0", r, hi, dz); end
  endtask

  task automatic test_divzero();
    int lat, bc;
    run_op(DIVU, 32'd9, 32'd0, lat, bc);
    checks++; if ({r, hi} !== {32'hFFFFFFFF, 32'd9}) begin errors++; $display("FAIL divz_result got q %h r %h exp ffffffff 9", r, hi); end
    checks++; if (dz !== 1'b1) begin errors++; $display("FAIL divz_dz got %b exp 1", dz); end
    checks++; if (lat !== 1 || bc !== 1) begin errors++; $display("FAIL divz_timing lat %0d busy %0d exp 1 1", lat, bc); end
    run_op(ADD, 32'd2, 32'd3, lat, bc);
    checks++; if ({r, dz} !== {32'd5, 1'b0}) begin errors++; $display("FAIL divz_clear got r %0d dz %b exp 5 0", r, dz); end
  endtask

  task automatic test_back_to_back();
    a = 32'd1; b = 32'd2; aluc = ADD; start = 1'b1;
    @(negedge clk);
    checks++; if ({ready, r} !== {1'b1, 32'd3}) begin errors++; $display("FAIL b2b_first got rdy %b r %h exp 1 3", ready, r); end
    a = 32'hF0F0; b = 32'h0FF0; aluc = XOR;
    @(negedge clk);
    checks++; if ({ready, r} !== {1'b1, 32'hFF00}) begin errors++; $display("FAIL b2b_xor got rdy %b r %h exp 1 ff00", ready, r); end
    aluc = AND;
    @(negedge clk);
    checks++; if ({ready, r} !== {1'b1, 32'h00F0}) begin errors++; $display("FAIL b2b_and got rdy %b r %h exp 1 f0", ready, r); end
    start = 1'b0; a = 32'd7;
    repeat (2) @(negedge clk);
    checks++; if ({ready, r, busy} !== {1'b0, 32'h00F0, 1'b0}) begin errors++; $display("FAIL hold got rdy %b r %h busy %b exp 0 f0 0", ready, r, busy); end
  endtask

  task automatic test_busy_ignore();
    int lat;
    a = 32'd6; b = 32'd7; aluc = MULTU; start = 1'b1;
    @(negedge clk);
    start = 1'b0; lat = 0;
    repeat (4) begin @(negedge clk); lat++; end
    a = 32'd1; b = 32'd1; aluc = ADD; start = 1'b1;
    @(negedge clk); lat++;
    start = 1'b0;
    checks++; if ({ready, busy, r} !== {1'b0, 1'b1, 32'h00F0}) begin errors++; $display("FAIL busy_ignore got rdy %b busy %b r %h exp 0 1 f0", ready, busy, r); end
    while (!ready && lat < 100) begin @(negedge clk); lat++; end
    checks++; if ({hi, r, lat} !== {32'd0, 32'd42, 33}) begin errors++; $display("FAIL busy_mul got hi %h r %0d lat %0d exp 0 42 33", hi, r, lat); end
    @(negedge clk);
    checks++; if (ready !== 1'b0) begin errors++; $display("FAIL busy_no_queue got rdy %b exp 0", ready); end
  endtask

  task automatic test_clrn_abort();
    int lat, bc;
    a = 32'hFFFFFFFD; b = 32'd5; aluc = MULT; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    clrn = 1'b0;
    #1;
    checks++; if ({r, hi} !== 64'h0) begin errors++; $display("FAIL abort_data got %h_%h exp 0", hi, r); end
    checks++; if ({z, dz, busy, ready} !== 4'b1000) begin errors++; $display("FAIL abort_flags got %b exp 1000", {z, dz, busy, ready}); end
    @(negedge clk);
    clrn = 1'b1;
    repeat (3) begin
      @(negedge clk);
      checks++; if ({ready, busy} !== 2'b00) begin errors++; $display("FAIL abort_quiet got rdy %b busy %b exp 0 0", ready, busy); end
    end
    run_op(MULTU, 32'd3, 32'd4, lat, bc);
    checks++; if ({r, hi, lat} !== {32'd12, 32'd0, 33}) begin errors++; $display("FAIL abort_restart got r %0d hi %0d lat %0d exp 12 0 33", r, hi, lat); end
  endtask

  task automatic test_w16();
    int lat;
    run_op16(MULT, 16'hFFFD, 16'd5, lat);
    checks++; if ({hi16, r16} !== 32'hFFFF_FFF1) begin errors++; $display("FAIL w16_mult got %h_%h exp ffff_fff1", hi16, r16); end
    checks++; if (lat !== 17) begin errors++; $display("FAIL w16_latency got %0d exp 17", lat); end
    run_op16(DIV, 16'hFFF9, 16'd2, lat);
    checks++; if ({r16, hi16, lat} !== {16'hFFFD, 16'hFFFF, 17}) begin errors++; $display("FAIL w16_div got q %h r %h lat %0d exp fffd ffff 17", r16, hi16, lat); end
    run_op16(DIVU, 16'd100, 16'd7, lat);
    checks++; if ({r16, hi16} !== {16'd14, 16'd2}) begin errors++; $display("FAIL w16_divu got q %0d r %0d exp 14 2", r16, hi16); end
    run_op16(DIV, 16'h8000, 16'hFFFF, lat);
    checks++; if ({r16, hi16} !== {16'h8000, 16'h0}) begin errors++; $display("FAIL w16_div_min got q %h r %h exp 8000 0", r16, hi16); end
  endtask

  initial begin
    test_reset();
    test_alu();
    test_mul();
    test_div();
    test_divzero();
    test_back_to_back();
    test_busy_ignore();
    test_clrn_abort();
    test_w16();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
